ra: RTL and testbench

RA -- requirements
Module: ra

---
 rtl/ra.sv | 76 +++++++
 tb/tb_ra.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ra.sv
// Register array: four 8-bit data registers plus a flags register, with a
// priority-muxed shared read port, a gated flags port and direct register views.
module ra (
    input  logic       clk,
    input  logic       rst,
    input  logic       I0,
    input  logic       I1,
    input  logic       I2,
    input  logic       I3,
    input  logic       E0,
    input  logic       E1,
    input  logic       E2,
    input  logic       E3,
    input  logic       IF,
    input  logic       EF,
    input  logic       IMUL,
    input  logic       IDIV,
    input  logic [7:0] Din,
    input  logic [7:0] DinA,
    input  logic [7:0] Flags_in,
    output logic [7:0] Dout0,
    output logic [7:0] Flags_out,
    output logic [7:0] DR0,
    output logic [7:0] DR1,
    output logic [7:0] DR2,
    output logic [7:0] DR3
);

    localparam int NUM_REGS = 4;

    logic [NUM_REGS-1:0][7:0] r_q, r_d;
    logic [7:0]               f_q, f_d;
    logic [NUM_REGS-1:0]      ld;
    logic                     wide_ld;

    assign ld      = {I3, I2, I1, I0};
    assign wide_ld = IMUL | IDIV;

    always_comb begin
        r_d = r_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ld[i]) r_d[i] = Din;
        end
        // Multiply/divide results occupy R0:R1 and take precedence over I0/I1.
        if (wide_ld) begin
            r_d[0] = Din;
            r_d[1] = DinA;
        end
        f_d = IF ? Flags_in : f_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
            f_q <= '0;
        end else begin
            r_q <= r_d;
            f_q <= f_d;
        end
    end

    always_comb begin
        if (E0)      Dout0 = r_q[0];
        else if (E1) Dout0 = r_q[1];
        else if (E2) Dout0 = r_q[2];
        else if (E3) Dout0 = r_q[3];
        else         Dout0 = 8'h00;
    end

    assign Flags_out = EF ? f_q : 8'h00;
    assign DR0 = r_q[0];
    assign DR1 = r_q[1];
    assign DR2 = r_q[2];
    assign DR3 = r_q[3];

endmodule

// File: tb/tb_ra.sv
// Directed bench for the ra register array: loads, read priority, wide loads,
// flags, same-cycle load/read and asynchronous reset.
module tb_ra;

    logic       clk = 1'b0;
    logic       rst;
    logic       I0, I1, I2, I3, E0, E1, E2, E3;
    logic       IF, EF, IMUL, IDIV;
    logic [7:0] Din, DinA, Flags_in;
    logic [7:0] Dout0, Flags_out, DR0, DR1, DR2, DR3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ra dut (
        .clk(clk), .rst(rst),
        .I0(I0), .I1(I1), .I2(I2), .I3(I3),
        .E0(E0), .E1(E1), .E2(E2), .E3(E3),
        .IF(IF), .EF(EF), .IMUL(IMUL), .IDIV(IDIV),
        .Din(Din), .DinA(DinA), .Flags_in(Flags_in),
        .Dout0(Dout0), .Flags_out(Flags_out),
        .DR0(DR0), .DR1(DR1), .DR2(DR2), .DR3(DR3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        {I0, I1, I2, I3, E0, E1, E2, E3} = '0;
        {IF, EF, IMUL, IDIV} = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_ctl();
        Din = 8'hFF; DinA = 8'hFF; Flags_in = 8'hFF;
        I0 = 1'b1; IF = 1'b1;
        #3;
        E0 = 1'b1; EF = 1'b1;
        #1;
        n_cmp++;
        if ({DR0, DR1, DR2, DR3} !== 32'h0) begin
            n_err++; $display("FAIL reset_dr got=%h exp=%h", {DR0, DR1, DR2, DR3}, 32'h0);
        end
        n_cmp++;
        if (Dout0 !== 8'h00) begin
            n_err++; $display("FAIL reset_dout0 got=%h exp=00", Dout0);
        end
        tick();
        n_cmp++;
        if (Flags_out !== 8'h00 || DR0 !== 8'h00) begin
            n_err++; $display("FAIL reset_ignores_load flags=%h dr0=%h exp=00/00", Flags_out, DR0);
        end
        clear_ctl();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_load();
        logic [7:0] exp [4];
        for (int i = 0; i < 4; i++) begin
            {I3, I2, I1, I0} = 4'b0001 << i;
            Din = 8'd12 + 8'(i);
            exp[i] = Din;
            tick();
        end
        clear_ctl();
        n_cmp++;
        if ({DR0, DR1, DR2, DR3} !== {exp[0], exp[1], exp[2], exp[3]}) begin
            n_err++; $display("FAIL load_seq got=%h exp=%h", {DR0, DR1, DR2, DR3}, 32'h0C0D0E0F);
        end
    endtask

    task automatic test_read();
        for (int i = 0; i < 4; i++) begin
            {E3, E2, E1, E0} = 4'b0001 << i;
            tick();
            n_cmp++;
            if (Dout0 !== 8'd12 + 8'(i)) begin
                n_err++; $display("FAIL read_e%0d got=%0d exp=%0d", i, Dout0, 12 + i);
            end
        end
        clear_ctl();
        #1;
        n_cmp++;
        if (Dout0 !== 8'h00) begin
            n_err++; $display("FAIL read_none got=%h exp=00", Dout0);
        end
        E1 = 1'b1; E3 = 1'b1;
        #1;
        n_cmp++;
        if (Dout0 !== 8'd13) begin
            n_err++; $display("FAIL read_prio_e1e3 got=%0d exp=13", Dout0);
        end
        E0 = 1'b1;
        #1;
        n_cmp++;
        if (Dout0 !== 8'd12) begin
            n_err++; $display("FAIL read_prio_e0 got=%0d exp=12", Dout0);
        end
        clear_ctl();
    endtask

    task automatic test_mul();
        IMUL = 1'b1; Din = 8'd15; DinA = 8'd21;
        tick();
        clear_ctl();
        n_cmp++;
        if ({DR0, DR1, DR2, DR3} !== {8'd15, 8'd21, 8'd14, 8'd15}) begin
            n_err++; $display("FAIL mul_load got=%h exp=%h", {DR0, DR1, DR2, DR3}, 32'h0F150E0F);
        end
        E1 = 1'b1; Din = 8'd20;
        tick();
        n_cmp++;
        if (Dout0 !== 8'd21 || DR1 !== 8'd21) begin
            n_err++; $display("FAIL mul_hold dout0=%0d dr1=%0d exp=21/21", Dout0, DR1);
        end
        clear_ctl();
    endtask

    task automatic test_flags();
        IF = 1'b1; Flags_in = 8'd23;
        tick();
        IF = 1'b0; Flags_in = 8'd99; EF = 1'b1;
        #1;
        n_cmp++;
        if (Flags_out !== 8'd23) begin
            n_err++; $display("FAIL flags_read got=%0d exp=23", Flags_out);
        end
        tick();
        n_cmp++;
        if (Flags_out !== 8'd23) begin
            n_err++; $display("FAIL flags_hold got=%0d exp=23", Flags_out);
        end
        EF = 1'b0;
        #1;
        n_cmp++;
        if (Flags_out !== 8'h00) begin
            n_err++; $display("FAIL flags_gate got=%h exp=00", Flags_out);
        end
    endtask

    task automatic test_div();
        IDIV = 1'b1; I1 = 1'b1; Din = 8'd7; DinA = 8'd3;
        tick();
        clear_ctl();
        n_cmp++;
        if (DR0 !== 8'd7 || DR1 !== 8'd3) begin
            n_err++; $display("FAIL div_wins dr0=%0d dr1=%0d exp=7/3", DR0, DR1);
        end
        IMUL = 1'b1; IDIV = 1'b1; I2 = 1'b1; Din = 8'h09; DinA = 8'h08;
        tick();
        clear_ctl();
        n_cmp++;
        if ({DR0, DR1, DR2, DR3} !== 32'h0908090F) begin
            n_err++; $display("FAIL muldiv_both got=%h exp=0908090f", {DR0, DR1, DR2, DR3});
        end
        I2 = 1'b1; I3 = 1'b1; Din = 8'h5A;
        tick();
        clear_ctl();
        n_cmp++;
        if ({DR0, DR1, DR2, DR3} !== 32'h09085A5A) begin
            n_err++; $display("FAIL multi_load got=%h exp=09085a5a", {DR0, DR1, DR2, DR3});
        end
    endtask

    task automatic test_same_cycle();
        I2 = 1'b1; E2 = 1'b1; Din = 8'hC3;
        #1;
        n_cmp++;
        if (Dout0 !== 8'h5A) begin
            n_err++; $display("FAIL same_cycle_before got=%h exp=5a", Dout0);
        end
        tick();
        n_cmp++;
        if (Dout0 !== 8'hC3) begin
            n_err++; $display("FAIL same_cycle_after got=%h exp=c3", Dout0);
        end
        clear_ctl();
    endtask

    task automatic test_async_reset();
        I0 = 1'b1; Din = 8'h77; IF = 1'b1; Flags_in = 8'h11;
        E0 = 1'b1; EF = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({DR0, DR1, DR2, DR3, Dout0, Flags_out} !== 48'h0) begin
            n_err++; $display("FAIL async_rst got=%h exp=0", {DR0, DR1, DR2, DR3, Dout0, Flags_out});
        end
        E0 = 1'b0; E3 = 1'b1;
        #1;
        n_cmp++;
        if (Dout0 !== 8'h00) begin
            n_err++; $display("FAIL async_rst_dout_e3 got=%h exp=00", Dout0);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_cmp++;
        if (DR0 !== 8'h77 || Flags_out !== 8'h11) begin
            n_err++; $display("FAIL load_after_rst dr0=%h flags=%h exp=77/11", DR0, Flags_out);
        end
        clear_ctl();
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_load();
        test_read();
        test_mul();
        test_flags();
        test_div();
        test_same_cycle();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
